// File: rtl/shared_bus_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the shared output bus.
// The master side drives requests and out_ready; the slave side (arbiter) drives grants and the bus.
interface shared_bus_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 16
);
    localparam int unsigned OWNER_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        gnt;
    logic                    out_valid;
    logic [DATA_W-1:0]       out_data;
    logic                    out_last;
    logic [OWNER_W-1:0]      out_owner;
    logic                    out_ready;

    modport master (
        output req, req_data, req_last, out_ready,
        input  gnt, out_valid, out_data, out_last, out_owner
    );

    modport slave (
        input  req, req_data, req_last, out_ready,
        output gnt, out_valid, out_data, out_last, out_owner
    );
endinterface

// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter moving one owner's beats at a time onto a single registered output bus.
// Ownership ends on a last beat, a hold limit, or the owner withdrawing its request.
module shared_bus_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shared_bus_arbiter_if.slave  bus
);
    localparam int unsigned OWNER_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [OWNER_W-1:0]   r_owner;
    logic [OWNER_W-1:0]   r_last_owner;
    logic [CNT_W-1:0]     r_beat_cnt;
    logic                 r_out_valid;
    logic [DATA_W-1:0]    r_out_data;
    logic                 r_out_last;
    logic [OWNER_W-1:0]   r_out_owner;

    logic                 w_any_req;
    logic [OWNER_W-1:0]   w_sel;
    logic                 w_accept;
    logic                 w_release;
    logic                 w_force_last;
    logic [N_REQ-1:0]     w_gnt;
    logic [DATA_W-1:0]    w_data_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_split
        assign w_data_arr[g] = bus.req_data[g*DATA_W +: DATA_W];
    end

    assign w_any_req = |bus.req;

    // First set request searching upward from last_owner+1, wrapping.
    always_comb begin : rr_search
        int unsigned k;
        logic        found;
        w_sel = r_last_owner;
        found = 1'b0;
        k     = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            k = 32'(r_last_owner) + i;
            if (k >= N_REQ) begin
                k = k - N_REQ;
            end
            if (!found && bus.req[OWNER_W'(k)]) begin
                found = 1'b1;
                w_sel = OWNER_W'(k);
            end
        end
    end

    // Next-state, accept and release decisions.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_release    = 1'b0;
        w_force_last = 1'b0;
        w_gnt        = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_force_last = ((9'(r_beat_cnt) + 9'd1) == 9'(MAX_HOLD));
                if (bus.req[r_owner]) begin
                    w_accept = !r_out_valid || bus.out_ready;
                    if (w_accept) begin
                        w_gnt[r_owner] = 1'b1;
                        w_release      = bus.req_last[r_owner] || w_force_last;
                    end
                end else begin
                    w_release = 1'b1;
                end
                if (w_release) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Ownership bookkeeping; beat_cnt saturates at the hold limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= '0;
            r_last_owner <= OWNER_W'(N_REQ - 1);
            r_beat_cnt   <= '0;
        end else begin
            if (r_state == ST_IDLE && w_any_req) begin
                r_owner    <= w_sel;
                r_beat_cnt <= '0;
            end else if (w_accept && (r_beat_cnt < CNT_W'(MAX_HOLD))) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end
            if (w_release) begin
                r_last_owner <= r_owner;
            end
        end
    end

    // Output stage drains independently of ownership.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_owner <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data_arr[r_owner];
            r_out_last  <= bus.req_last[r_owner] || w_force_last;
            r_out_owner <= r_owner;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.out_owner = r_out_owner;

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Bench for shared_bus_arbiter: queued requesters, a transaction-level reference model,
// directed scenarios with literal expectations, then a randomized soak.
module tb_shared_bus_arbiter;
    localparam int unsigned N_REQ    = 4;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned MAX_HOLD = 4;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              l;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shared_bus_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

    shared_bus_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    beat_t            q [N_REQ][$];
    logic [N_REQ-1:0] drop;

    // reference model state
    bit                m_busy;
    int                m_owner;
    int                m_last_owner;
    int                m_cnt;
    bit                m_ov;
    logic [DATA_W-1:0] m_od;
    bit                m_ol;
    int                m_oo;
    logic [N_REQ-1:0]  m_gnt;

    // input snapshot and DUT sample of the current cycle
    logic [N_REQ-1:0]        s_req;
    logic [N_REQ-1:0]        s_last;
    logic [N_REQ*DATA_W-1:0] s_data;
    logic                    s_ready;
    logic [N_REQ-1:0]        a_gnt;
    logic                    a_ov;
    logic [DATA_W-1:0]       a_od;
    logic                    a_ol;
    logic [1:0]              a_oo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int i, input logic [DATA_W-1:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        q[i].push_back(b);
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N_REQ; i++) q[i].delete();
        drop = '0;
    endtask

    function automatic int rr_pick(input logic [N_REQ-1:0] r, input int last);
        int best  = -1;
        int bestd = 1000;
        int n     = N_REQ;
        for (int i = 0; i < n; i++) begin
            int d;
            d = (i - last - 1 + 2 * n) % n;
            if (r[i] && d < bestd) begin
                bestd = d;
                best  = i;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_busy       = 1'b0;
        m_owner      = 0;
        m_last_owner = N_REQ - 1;
        m_cnt        = 0;
        m_ov         = 1'b0;
        m_od         = '0;
        m_ol         = 1'b0;
        m_oo         = 0;
        m_gnt        = '0;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N_REQ; i++) begin
            if (q[i].size() > 0) begin
                bus.req[i]                         = !drop[i];
                bus.req_data[i*DATA_W +: DATA_W]   = q[i][0].d;
                bus.req_last[i]                    = q[i][0].l;
            end else begin
                bus.req[i]                         = 1'b0;
                bus.req_data[i*DATA_W +: DATA_W]   = '0;
                bus.req_last[i]                    = 1'b0;
            end
        end
    endtask

    // Advance the model by one clock edge using the snapshot of this cycle's inputs.
    task automatic model_edge();
        bit acc;
        bit lim;
        acc = (m_gnt != '0);
        lim = ((m_cnt + 1) == MAX_HOLD);
        if (acc) begin
            m_ov = 1'b1;
            m_od = s_data[m_owner*DATA_W +: DATA_W];
            m_ol = s_last[m_owner] || lim;
            m_oo = m_owner;
        end else if (m_ov && s_ready) begin
            m_ov = 1'b0;
        end
        if (!m_busy) begin
            if (s_req != '0) begin
                m_owner = rr_pick(s_req, m_last_owner);
                m_cnt   = 0;
                m_busy  = 1'b1;
            end
        end else if (!s_req[m_owner] || (acc && (s_last[m_owner] || lim))) begin
            m_busy       = 1'b0;
            m_last_owner = m_owner;
        end else if (acc) begin
            m_cnt++;
        end
    endtask

    // One clock: drive at negedge, compare before posedge, advance model and requesters.
    task automatic cycle();
        drive_inputs();
        #1;
        s_req   = bus.req;
        s_last  = bus.req_last;
        s_data  = bus.req_data;
        s_ready = bus.out_ready;
        m_gnt   = '0;
        if (m_busy && s_req[m_owner] && (!m_ov || s_ready)) m_gnt[m_owner] = 1'b1;
        a_gnt = bus.gnt;
        a_ov  = bus.out_valid;
        a_od  = bus.out_data;
        a_ol  = bus.out_last;
        a_oo  = bus.out_owner;
        check("gnt", 32'(a_gnt), 32'(m_gnt));
        check("gnt_onehot", 32'($countones(a_gnt) <= 1), 32'h1);
        check("out_valid", 32'(a_ov), 32'(m_ov));
        check("out_data", 32'(a_od), 32'(m_od));
        check("out_last", 32'(a_ol), 32'(m_ol));
        check("out_owner", 32'(a_oo), 32'(m_oo));
        @(posedge clk);
        model_edge();
        for (int i = 0; i < N_REQ; i++) begin
            if (m_gnt[i] && q[i].size() > 0) void'(q[i].pop_front());
        end
        @(negedge clk);
    endtask

    // Assert reset at a negedge; outputs must clear without waiting for a clock.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst gnt", 32'(bus.gnt), 32'h0);
        check("rst out_valid", 32'(bus.out_valid), 32'h0);
        check("rst out_data", 32'(bus.out_data), 32'h0);
        check("rst out_last", 32'(bus.out_last), 32'h0);
        check("rst out_owner", 32'(bus.out_owner), 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.req       = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.out_ready = 1'b1;
        drop          = '0;
        model_reset();
        @(negedge clk);

        // single requester, 3-beat burst
        clear_reqs();
        apply_reset();
        push(0, 16'h1111, 1'b0);
        push(0, 16'h2222, 1'b0);
        push(0, 16'h3333, 1'b1);
        cycle(); check("t1 c0 gnt", 32'(a_gnt), 32'h0);
        cycle(); check("t1 c1 gnt", 32'(a_gnt), 32'h1); check("t1 c1 ov", 32'(a_ov), 32'h0);
        cycle(); check("t1 c2 gnt", 32'(a_gnt), 32'h1); check("t1 c2 od", 32'(a_od), 32'h1111);
        cycle(); check("t1 c3 gnt", 32'(a_gnt), 32'h1); check("t1 c3 od", 32'(a_od), 32'h2222);
        cycle(); check("t1 c4 gnt", 32'(a_gnt), 32'h0); check("t1 c4 od", 32'(a_od), 32'h3333);
                 check("t1 c4 ol", 32'(a_ol), 32'h1);
        cycle(); check("t1 c5 ov", 32'(a_ov), 32'h0);

        // all four requesting single-beat bursts
        clear_reqs();
        apply_reset();
        for (int i = 0; i < N_REQ; i++)
            for (int k = 0; k < 3; k++) push(i, 16'(16'hA000 + i * 16 + k), 1'b1);
        for (int k = 0; k < 10; k++) begin
            logic [N_REQ-1:0] eg;
            eg = '0;
            if (k % 2 == 1) eg[((k - 1) / 2) % 4] = 1'b1;
            cycle();
            check("t2 gnt", 32'(a_gnt), 32'(eg));
            if (k >= 2) check("t2 ov", 32'(a_ov), 32'(k % 2 == 0));
            if (k >= 2 && k % 2 == 0) check("t2 owner", 32'(a_oo), 32'(((k - 2) / 2) % 4));
        end

        // hold limit forces release, next requester gets the bus
        clear_reqs();
        apply_reset();
        for (int k = 0; k < 8; k++) push(2, 16'(16'h2000 + k), k == 7);
        push(3, 16'h3000, 1'b1);
        cycle(); check("t3 c0 gnt", 32'(a_gnt), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            cycle(); check("t3 burst gnt", 32'(a_gnt), 32'h4);
        end
        cycle(); check("t3 c5 gnt", 32'(a_gnt), 32'h0); check("t3 c5 od", 32'(a_od), 32'h2003);
                 check("t3 c5 ol", 32'(a_ol), 32'h1);
        cycle(); check("t3 c6 gnt", 32'(a_gnt), 32'h8);
        cycle(); check("t3 c7 od", 32'(a_od), 32'h3000); check("t3 c7 oo", 32'(a_oo), 32'h3);
        cycle(); check("t3 c8 gnt", 32'(a_gnt), 32'h4);
        cycle(); check("t3 c9 od", 32'(a_od), 32'h2004); check("t3 c9 ol", 32'(a_ol), 32'h0);

        // back-pressure stall
        clear_reqs();
        apply_reset();
        for (int k = 0; k < 4; k++) push(0, 16'(16'hB000 + k), k == 3);
        cycle();
        cycle(); check("t4 c1 gnt", 32'(a_gnt), 32'h1);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("t4 stall gnt", 32'(a_gnt), 32'h0);
            check("t4 stall od", 32'(a_od), 32'hB000);
            check("t4 stall ov", 32'(a_ov), 32'h1);
        end
        bus.out_ready = 1'b1;
        cycle(); check("t4 resume gnt", 32'(a_gnt), 32'h1);
        cycle(); check("t4 resume od", 32'(a_od), 32'hB001);

        // withdrawal by owner 1
        clear_reqs();
        apply_reset();
        for (int k = 0; k < 4; k++) push(1, 16'(16'hC000 + k), k == 3);
        cycle();
        cycle(); check("t5 c1 gnt", 32'(a_gnt), 32'h2);
        cycle(); check("t5 c2 gnt", 32'(a_gnt), 32'h2);
        drop[1] = 1'b1;
        cycle(); check("t5 drop gnt", 32'(a_gnt), 32'h0);
        drop[1] = 1'b0;
        push(0, 16'hD000, 1'b1);
        push(2, 16'hE000, 1'b1);
        cycle(); check("t5 idle gnt", 32'(a_gnt), 32'h0);
        cycle(); check("t5 next gnt", 32'(a_gnt), 32'h4);
        cycle();
        cycle(); check("t5 after gnt", 32'(a_gnt), 32'h1);

        // reset in the middle of a burst
        clear_reqs();
        apply_reset();
        for (int i = 0; i < N_REQ; i++)
            for (int k = 0; k < 6; k++) push(i, 16'(16'hF000 + i * 16 + k), k == 5);
        cycle();
        cycle();
        cycle(); check("t6 ov before rst", 32'(a_ov), 32'h1);
        apply_reset();
        cycle(); check("t6 c0 gnt", 32'(a_gnt), 32'h0);
        cycle(); check("t6 c1 gnt", 32'(a_gnt), 32'h1);

        // randomized soak against the model
        clear_reqs();
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (q[i].size() == 0 && $urandom_range(0, 7) == 0) begin
                    int len;
                    len = $urandom_range(1, 10);
                    for (int k = 0; k < len; k++) push(i, 16'($urandom), k == len - 1);
                end
                drop[i] = ($urandom_range(0, 19) == 0);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (c == 2000) apply_reset();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/shared_bus_arbiter.md
# shared_bus_arbiter

Round-robin arbiter that shares one registered 16-bit output bus among several instance-level requesters. It decides which requester owns the bus, moves that requester's beats onto the bus with a valid/ready handshake, and releases ownership on a last beat, a hold limit, or a dropped request. It sits between the replicated leaf instances and the single top-level output bus. It replaces direct multi-driver connections on shared nets with a single, sequenced driver.

## Interface
- N_REQ, 4, number of requesters (2..16)
- DATA_W, 16, beat width
- MAX_HOLD, 4, maximum beats per grant before forced release (1..255)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N_REQ  per-requester beat available; level, held until acknowledged
- req_data  input  N_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W]
- req_last  input  N_REQ  marks the current beat as the final beat of requester i's burst
- gnt  output  N_REQ  one-hot, combinational; pulses in the cycle requester i's beat is accepted
- out_valid  output  1  registered; out_data holds a beat
- out_data  output  DATA_W  registered beat
- out_last  output  1  registered copy of the accepted beat's req_last, or forced 1 on a hold-limit release
- out_owner  output  clog2(N_REQ)  registered index of the requester that supplied out_data
- out_ready  input  1  downstream accepts the beat when out_valid && out_ready

## Operation
- FSM has two states:
  - IDLE: no owner, gnt=0.
  - BUSY: owner locked, beats flow.
- IDLE with any req set:
  - Select the first set req searching upward from last_owner+1, wrapping modulo N_REQ.
  - Latch the result into owner and go to BUSY.
  - Clear beat_cnt to 0.
- IDLE with req=0: stay in IDLE.
- BUSY, beat acceptance:
  - accept = req[owner] && (!out_valid || out_ready).
  - On accept: gnt[owner]=1. Register req_data, the owner index, and the last flag into the output stage. Set out_valid=1. Increment beat_cnt.
  - If out_valid && out_ready and there is no accept, clear out_valid to 0.
- BUSY, release. Leave BUSY for IDLE and set last_owner=owner when any of these holds:
  - accept && req_last[owner];
  - accept && beat_cnt+1 == MAX_HOLD (out_last is forced to 1 on this beat);
  - !req[owner] (requester withdrew; no beat taken that cycle).
- The output stage drains independently of the state. A beat that is still pending keeps its out_owner after release.
- beat_cnt is 8 bits and saturates at MAX_HOLD. It never wraps.
- Requests from non-owners are ignored while in BUSY. gnt never has more than one bit set.
- Reset values:
  - state=IDLE, last_owner=N_REQ-1 (so requester 0 wins first);
  - beat_cnt=0, gnt=0;
  - out_valid=0, out_data=0, out_last=0, out_owner=0.
- Reset mid-burst: all state clears immediately. Any pending beat is dropped and no gnt is issued. After reset release, arbitration restarts from requester 0.

## Timing
- Arbitration takes 1 cycle. Req rising in IDLE at cycle t gives BUSY at t+1, gnt at t+1 (if the output stage is free), and out_valid at t+2.
- Within a grant, throughput is 1 beat/cycle while out_ready=1.
- Back-pressure: out_valid, out_data, out_last and out_owner stay stable while out_valid && !out_ready. gnt stays 0 until the stage frees. An accept in the same cycle that out_ready drains the stage is allowed.
- Ownership hand-off costs exactly 1 IDLE cycle between the last gnt of one owner and the first gnt of the next.
- Requester protocol: req_data and req_last must be stable while req=1 and gnt=0. The requester may drop req only in a cycle it receives no gnt.

## Test plan
- Single requester, burst 3 beats (0x1111, 0x2222, 0x3333 with last on the third), out_ready=1 -> gnt[0] in cycles 1-3; out_valid in cycles 2-4 with those data; out_last=1 on 0x3333; state IDLE in cycle 4.
- All 4 requesting continuous single-beat bursts (last=1) -> grant order 0,1,2,3,0; exactly one IDLE cycle between grants; out_owner follows the same sequence.
- Requester 2 with an 8-beat burst, MAX_HOLD=4 -> release after 4 beats with out_last forced 1; requester 3 (also requesting) is granted next; requester 2 resumes after it.
- Back-pressure: hold out_ready=0 for 5 cycles after the first beat -> out_data stable at the first beat, gnt=0 during the stall; the second beat is accepted in the cycle out_ready returns to 1.
- Withdrawal: owner 1 drops req mid-burst with no last -> no gnt that cycle, return to IDLE; the next search starts at 2.
- Assert rst_n=0 mid-burst with out_valid=1 -> out_valid=0, gnt=0 immediately (asynchronous); after release with req=4'b1111, the first gnt goes to requester 0.
